// File: rtl/ninjakun_pkg.sv
// Shared types and widths for the Ninjakun hiscore transfer engine.
package ninjakun_pkg;

  localparam int FG_AW = 11;  // foreground VRAM byte address width
  localparam int HS_AW = 16;  // hiscore port address width

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_S_ADDR,
    ST_S_WAIT,
    ST_S_SEND,
    ST_L_RECV,
    ST_L_WRITE,
    ST_SUM,
    ST_RELEASE,
    ST_FIN
  } xfer_state_t;

  typedef enum logic {
    MODE_SAVE = 1'b0,
    MODE_LOAD = 1'b1
  } xfer_mode_t;

  // Region addresses wrap modulo the VRAM size.
  function automatic logic [FG_AW-1:0] fg_addr(input logic [FG_AW-1:0] base,
                                               input logic [11:0]       idx);
    return base + idx[FG_AW-1:0];
  endfunction

endpackage

// File: rtl/hs_settle_cnt.sv
// Loadable down-counter with zero flag; load has priority, stops at zero.
module hs_settle_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ninjakun_hiscore_xfer.sv
// Hiscore save/load engine: pauses the core, owns FG VRAM, streams a region out or back in.
// Save 3 cycles/byte, load 2 cycles/byte; stalls on TX/RX handshakes indefinitely. HS_CHECKSUM_EN adds a sum byte.
module ninjakun_hiscore_xfer
  import ninjakun_pkg::*;
#(
  parameter logic [FG_AW-1:0] BASE   = 11'h000,
  parameter int               LENGTH = 64,
  parameter int               SETTLE = 16
) (
  input  logic             ROMCL,
  input  logic             RESET_L,
  input  logic             START_SAVE,
  input  logic             START_LOAD,
  output logic             PAUSE_REQ,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [7:0]       TX_DATA,
  output logic             TX_VALID,
  input  logic             TX_READY,
  input  logic [7:0]       RX_DATA,
  input  logic             RX_VALID,
  output logic             RX_READY,
  output logic [HS_AW-1:0] HS_ADDR,
  output logic [7:0]       HS_WDATA,
  input  logic [7:0]       HS_RDATA,
  output logic             HS_WRITE,
  output logic             HS_ACCESS
);

  localparam logic [11:0] LAST_IDX  = 12'(LENGTH - 1);
  localparam logic [15:0] SETTLE_LD = 16'(SETTLE - 1);

`ifdef HS_CHECKSUM_EN
  localparam xfer_state_t AFTER_DATA = ST_SUM;
`else
  localparam xfer_state_t AFTER_DATA = ST_RELEASE;
`endif

  xfer_state_t      state_q, state_d;
  xfer_mode_t       mode_q, mode_d;
  logic [11:0]      idx_q, idx_d;
  logic [FG_AW-1:0] addr_q, addr_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic             last_byte;
`ifdef HS_CHECKSUM_EN
  logic [7:0]       sum_q, sum_d;
  logic             err_q, err_d;
`endif

  assign last_byte = (idx_q == LAST_IDX);

  hs_settle_cnt #(.W(16)) u_settle (
    .clk      (ROMCL),
    .rst_n    (RESET_L),
    .load     (cnt_load),
    .load_val (SETTLE_LD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    tx_data_d = tx_data_q;
    wdata_d   = wdata_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
`ifdef HS_CHECKSUM_EN
    sum_d     = sum_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (START_SAVE || START_LOAD) begin
          mode_d   = START_SAVE ? MODE_SAVE : MODE_LOAD;
          idx_d    = '0;
          cnt_load = 1'b1;
          state_d  = ST_SETTLE;
`ifdef HS_CHECKSUM_EN
          sum_d    = '0;
          err_d    = 1'b0;
`endif
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) begin
          addr_d  = fg_addr(BASE, idx_q);
          state_d = (mode_q == MODE_SAVE) ? ST_S_ADDR : ST_L_RECV;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_S_ADDR: state_d = ST_S_WAIT;
      ST_S_WAIT: begin
        // Read data is valid one cycle after the address was presented.
        tx_data_d = HS_RDATA;
        state_d   = ST_S_SEND;
      end
      ST_S_SEND: begin
        if (TX_READY) begin
          idx_d = idx_q + 12'd1;
`ifdef HS_CHECKSUM_EN
          sum_d = sum_q + tx_data_q;
`endif
          if (last_byte) begin
            state_d = AFTER_DATA;
`ifdef HS_CHECKSUM_EN
            tx_data_d = sum_d;
`endif
          end else begin
            addr_d  = fg_addr(BASE, idx_d);
            state_d = ST_S_ADDR;
          end
        end
      end
      ST_L_RECV: begin
        if (RX_VALID) begin
          wdata_d = RX_DATA;
`ifdef HS_CHECKSUM_EN
          sum_d   = sum_q + RX_DATA;
`endif
          state_d = ST_L_WRITE;
        end
      end
      ST_L_WRITE: begin
        idx_d = idx_q + 12'd1;
        if (last_byte) begin
          state_d = AFTER_DATA;
        end else begin
          addr_d  = fg_addr(BASE, idx_d);
          state_d = ST_L_RECV;
        end
      end
      ST_SUM: begin
`ifdef HS_CHECKSUM_EN
        if (mode_q == MODE_SAVE) begin
          if (TX_READY) state_d = ST_RELEASE;
        end else if (RX_VALID) begin
          err_d   = (RX_DATA != sum_q);
          state_d = ST_RELEASE;
        end
`else
        state_d = ST_RELEASE;
`endif
      end
      ST_RELEASE: state_d = ST_FIN;
      ST_FIN:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ROMCL or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_SAVE;
      idx_q     <= '0;
      addr_q    <= '0;
      tx_data_q <= '0;
      wdata_q   <= '0;
`ifdef HS_CHECKSUM_EN
      sum_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      tx_data_q <= tx_data_d;
      wdata_q   <= wdata_d;
`ifdef HS_CHECKSUM_EN
      sum_q     <= sum_d;
      err_q     <= err_d;
`endif
    end
  end

  // Handshake and bus controls decode straight from state so reset drops them at once.
  assign BUSY      = (state_q != ST_IDLE);
  assign PAUSE_REQ = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign DONE      = (state_q == ST_FIN);
  assign HS_ACCESS = (state_q == ST_S_ADDR) || (state_q == ST_S_WAIT) ||
                     (state_q == ST_S_SEND) || (state_q == ST_L_RECV) ||
                     (state_q == ST_L_WRITE) || (state_q == ST_SUM);
  assign TX_VALID  = (state_q == ST_S_SEND) ||
                     ((state_q == ST_SUM) && (mode_q == MODE_SAVE));
  assign RX_READY  = (state_q == ST_L_RECV) ||
                     ((state_q == ST_SUM) && (mode_q == MODE_LOAD));
  assign HS_WRITE  = (state_q == ST_L_WRITE);
  assign HS_ADDR   = {{(HS_AW-FG_AW){1'b0}}, addr_q};
  assign HS_WDATA  = wdata_q;
  assign TX_DATA   = tx_data_q;
`ifdef HS_CHECKSUM_EN
  assign ERR       = err_q;
`else
  assign ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_ninjakun_hiscore_xfer.sv
// Directed bench for ninjakun_hiscore_xfer with a VRAM model and a per-cycle protocol/data checker.
module tb_ninjakun_hiscore_xfer;

  localparam logic [10:0] BASE   = 11'h7FE;
  localparam int          LENGTH = 4;
  localparam int          SETTLE = 2;
`ifdef HS_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        ROMCL = 1'b0;
  logic        RESET_L = 1'b1;
  logic        START_SAVE = 1'b0, START_LOAD = 1'b0;
  logic        PAUSE_REQ, BUSY, DONE, ERR;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b0;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic        RX_READY;
  logic [15:0] HS_ADDR;
  logic [7:0]  HS_WDATA;
  logic [7:0]  HS_RDATA;
  logic        HS_WRITE, HS_ACCESS;

  ninjakun_hiscore_xfer #(.BASE(BASE), .LENGTH(LENGTH), .SETTLE(SETTLE)) dut (
    .ROMCL(ROMCL), .RESET_L(RESET_L), .START_SAVE(START_SAVE), .START_LOAD(START_LOAD),
    .PAUSE_REQ(PAUSE_REQ), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .HS_ADDR(HS_ADDR), .HS_WDATA(HS_WDATA), .HS_RDATA(HS_RDATA),
    .HS_WRITE(HS_WRITE), .HS_ACCESS(HS_ACCESS)
  );

  always #5 ROMCL = ~ROMCL;

  // Video-block VRAM: synchronous read, one-cycle latency.
  logic [7:0] vram [0:2047];
  always @(posedge ROMCL) begin
    HS_RDATA <= vram[HS_ADDR[10:0]];
    if (HS_WRITE && HS_ACCESS) vram[HS_ADDR[10:0]] <= HS_WDATA;
  end

  int tests = 0, fails = 0, cyc = 0;
  logic [7:0]  model_mem [0:2047];
  logic [7:0]  exp_tx[$];
  logic [23:0] exp_wr[$];
  logic [7:0]  tx_log[$];
  bit          tx_ready_held = 1'b0;
  int          done_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] sum8(input logic [7:0] q[$]);
    logic [7:0] s;
    s = 8'h00;
    foreach (q[i]) s = s + q[i];
    return s;
  endfunction

  // Expected behaviour derived from the region definition: byte i lives at (BASE+i) mod 2048.
  task automatic expect_load(input logic [7:0] d[$]);
    for (int i = 0; i < LENGTH; i++) begin
      logic [10:0] a;
      a = BASE + 11'(i);
      exp_wr.push_back({5'b0, a, d[i]});
      model_mem[a] = d[i];
    end
  endtask

  task automatic expect_save();
    logic [7:0] d[$];
    for (int i = 0; i < LENGTH; i++) d.push_back(model_mem[BASE + 11'(i)]);
    foreach (d[i]) exp_tx.push_back(d[i]);
    if (CSUM) exp_tx.push_back(sum8(d));
  endtask

  // Per-cycle checker.
  bit prev_pause, prev_acc, prev_txv, prev_txr, first_tx_pending;
  logic [7:0] prev_txd;
  int pause_rise, acc_rise, last_wr = -1, last_cmpl = -1, data_tx_cnt, last_data_tx = -1;
  logic [23:0] w;

  always @(negedge ROMCL) begin
    if (!RESET_L) begin
      prev_pause = 0; prev_acc = 0; prev_txv = 0; prev_txr = 0;
      first_tx_pending = 0; last_wr = -1; last_cmpl = -1;
    end else begin
      if (PAUSE_REQ && !prev_pause) begin
        pause_rise = cyc; last_wr = -1; last_cmpl = -1; data_tx_cnt = 0; last_data_tx = -1;
      end
      if (HS_ACCESS && !prev_acc) begin
        chk("settle_latency", cyc - pause_rise, SETTLE);
        acc_rise = cyc; first_tx_pending = 1;
      end
      if (TX_VALID && first_tx_pending) begin
        chk("tx_first_latency", cyc - acc_rise, 2);
        first_tx_pending = 0;
      end
      if (RX_READY) first_tx_pending = 0;
      if (prev_txv && !prev_txr) begin
        chk("tx_hold_valid", TX_VALID, 1);
        chk("tx_hold_data", TX_DATA, prev_txd);
        chk("tx_hold_access", HS_ACCESS, 1);
      end
      if (TX_VALID && TX_READY) begin
        if (exp_tx.size() == 0) chk("tx_extra", TX_DATA, 32'hFFFF_FFFF);
        else chk("tx_byte", TX_DATA, exp_tx.pop_front());
        tx_log.push_back(TX_DATA);
        if (data_tx_cnt < LENGTH) begin
          if (tx_ready_held && last_data_tx >= 0) chk("tx_spacing", cyc - last_data_tx, 3);
          last_data_tx = cyc;
          data_tx_cnt++;
        end
        last_cmpl = cyc;
      end
      if (RX_VALID && RX_READY) last_cmpl = cyc;
      if (HS_WRITE) begin
        chk("wr_with_access", HS_ACCESS, 1);
        if (exp_wr.size() == 0) chk("wr_extra", HS_ADDR, 32'hFFFF_FFFF);
        else begin
          w = exp_wr.pop_front();
          chk("wr_addr", HS_ADDR, w[23:8]);
          chk("wr_data", HS_WDATA, w[7:0]);
        end
        if (last_wr >= 0) chk("wr_spacing", cyc - last_wr, 2);
        last_wr = cyc; last_cmpl = cyc;
      end
      if (HS_ACCESS) chk("access_in_pause", PAUSE_REQ, 1);
      chk("busy_decode", BUSY, PAUSE_REQ | DONE);
      if (DONE) begin
        done_seen++;
        chk("done_latency", cyc - last_cmpl, 2);
        chk("done_released", {PAUSE_REQ, HS_ACCESS}, 0);
      end
      prev_pause = PAUSE_REQ; prev_acc = HS_ACCESS;
      prev_txv = TX_VALID; prev_txr = TX_READY; prev_txd = TX_DATA;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge ROMCL); #1;
  endtask

  task automatic pulse_start(input bit s, input bit l);
    tick();
    START_SAVE = s; START_LOAD = l;
    tick();
    START_SAVE = 0; START_LOAD = 0;
    chk("start_to_pause", PAUSE_REQ, 1);
  endtask

  task automatic send_rx(input logic [7:0] q[$]);
    foreach (q[i]) begin
      int n;
      bit rdy;
      RX_DATA = q[i]; RX_VALID = 1; n = 0;
      do begin
        @(negedge ROMCL); rdy = RX_READY;
        tick(); n++;
      end while (!rdy && n < 300);
      if (!rdy) chk("rx_timeout", 0, 1);
    end
    RX_VALID = 0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge ROMCL); n++;
    end while (!DONE && n < 2000);
    chk(nm, DONE, 1);
    tick();
  endtask

  task automatic cmp_log(input string nm, input logic [7:0] lit[$]);
    chk({nm, "_count"}, tx_log.size(), lit.size());
    foreach (lit[i]) chk(nm, (i < tx_log.size()) ? {24'h0, tx_log[i]} : 32'hFFFF_FFFF, lit[i]);
  endtask

  initial begin
    logic [7:0] d[$], rx[$], lit[$];
    int dbase, nw, n;

    // Reset state
    #2 RESET_L = 0;
    #20;
    chk("rst_outputs", {PAUSE_REQ, BUSY, DONE, ERR, TX_VALID, RX_READY, HS_WRITE, HS_ACCESS}, 0);
    chk("rst_hs_addr", HS_ADDR, 0);
    chk("rst_tx_data", TX_DATA, 0);
    chk("rst_wdata", HS_WDATA, 0);
    @(posedge ROMCL); #1 RESET_L = 1;
    tick();

    // Good load across the wrap point
    d = {8'h11, 8'h22, 8'h33, 8'h44};
    expect_load(d);
    rx = d;
    if (CSUM) rx.push_back(sum8(d));
    dbase = done_seen;
    pulse_start(0, 1);
    send_rx(rx);
    wait_done("load1_done");
    chk("load1_err", ERR, 0);
    chk("load1_writes_left", exp_wr.size(), 0);
    chk("load1_done_once", done_seen - dbase, 1);
    chk("vram_7fe", vram[11'h7FE], 8'h11);
    chk("vram_7ff", vram[11'h7FF], 8'h22);
    chk("vram_000", vram[11'h000], 8'h33);
    chk("vram_001", vram[11'h001], 8'h44);

    // Save with TX_READY held high
    tx_ready_held = 1; TX_READY = 1;
    tx_log.delete();
    expect_save();
    dbase = done_seen;
    pulse_start(1, 0);
    wait_done("save1_done");
    chk("save1_tx_left", exp_tx.size(), 0);
    chk("save1_done_once", done_seen - dbase, 1);
    lit = {8'h11, 8'h22, 8'h33, 8'h44};
`ifdef HS_CHECKSUM_EN
    lit.push_back(8'hAA);
`endif
    cmp_log("save1_literal", lit);

    // Load with a bad checksum byte
    d = {8'h01, 8'h02, 8'h03, 8'h04};
    expect_load(d);
    rx = d;
`ifdef HS_CHECKSUM_EN
    rx.push_back(8'h0B);
`endif
    pulse_start(0, 1);
    send_rx(rx);
    wait_done("load_bad_done");
    chk("load_bad_err", ERR, 32'(CSUM));
    chk("load_bad_vram_7fe", vram[11'h7FE], 8'h01);
    chk("load_bad_vram_001", vram[11'h001], 8'h04);
    repeat (5) tick();
    chk("err_sticky", ERR, 32'(CSUM));

    // Simultaneous starts: save wins, ERR clears, a later START_LOAD is ignored
    tx_log.delete();
    expect_save();
    dbase = done_seen;
    pulse_start(1, 1);
    chk("err_cleared_on_start", ERR, 0);
    chk("both_starts_no_rx", RX_READY, 0);
    repeat (6) tick();
    START_LOAD = 1; tick(); START_LOAD = 0;
    chk("busy_load_ignored_rx", RX_READY, 0);
    wait_done("save2_done");
    chk("save2_tx_left", exp_tx.size(), 0);
    chk("save2_done_once", done_seen - dbase, 1);
    lit = {8'h01, 8'h02, 8'h03, 8'h04};
`ifdef HS_CHECKSUM_EN
    lit.push_back(8'h0A);
`endif
    cmp_log("save2_literal", lit);
    repeat (3) tick();
    chk("idle_after_ignored_load", BUSY, 0);

    // Save with a 100-cycle TX stall after the first byte
    tx_ready_held = 0; TX_READY = 0;
    tx_log.delete();
    expect_save();
    pulse_start(1, 0);
    n = 0;
    while (!TX_VALID && n < 200) begin tick(); n++; end
    chk("stall_first_valid", TX_VALID, 1);
    TX_READY = 1; tick(); TX_READY = 0;
    repeat (100) tick();
    chk("stall_valid", TX_VALID, 1);
    chk("stall_access", HS_ACCESS, 1);
    chk("stall_data", TX_DATA, 8'h02);
    TX_READY = 1;
    wait_done("stall_done");
    chk("stall_tx_left", exp_tx.size(), 0);

    // Reset during the second L_WRITE
    exp_wr.push_back({5'b0, BASE, 8'h77});
    exp_wr.push_back({5'b0, BASE + 11'd1, 8'h88});
    model_mem[BASE] = 8'h77;
    RX_DATA = 8'h77; RX_VALID = 1;
    pulse_start(0, 1);
    nw = 0; n = 0;
    while (nw < 2 && n < 200) begin
      tick(); n++;
      if (HS_WRITE) begin
        nw++;
        if (nw == 1) RX_DATA = 8'h88;
      end
    end
    chk("reset_reached_write", nw, 2);
    RESET_L = 0;
    #1;
    chk("arst_hs_write", HS_WRITE, 0);
    chk("arst_hs_access", HS_ACCESS, 0);
    chk("arst_pause", PAUSE_REQ, 0);
    RX_VALID = 0;
    exp_wr.delete();
    tick();
    RESET_L = 1;
    tick();
    chk("post_reset_idle", BUSY, 0);
    chk("post_reset_rx_ready", RX_READY, 0);
    chk("kept_write_7fe", vram[11'h7FE], 8'h77);
    chk("aborted_write_7ff", vram[11'h7FF], 8'h02);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
